mem_port_arbiter: RTL and testbench

Shares the single byte-wide RAM/IO port between the instruction-fetch requester (ICache) and the load/store requester (LSB). It sequences 1/2/4-byte accesses as byte transfers and assembles read bytes little-endian. It sign- or zero-extends loads, stalls IO writes on a full UART buffer, and aborts speculative traffic on branch mispredict. It sits between ICache/LSB and the top-level mem_* pins.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Byte-wide memory port arbiter between instruction fetch (IC) and load/store (LSB) requesters.
// Define MEM_ARB_LSB_PRIO_EN for fixed LSB priority on ties; the default is round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jp_wrong,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [2:0]        lsb_insty,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_data,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  localparam logic [2:0] FETCH_N = 3'(FETCH_BYTES);

  state_t            state, state_nxt;
  logic [2:0]        cnt, n_bytes, lsb_n;
  logic [ADDR_W-1:0] base, cur_addr;
  logic [31:0]       wdata, rbuf, rd_word, ext_word;
  logic [2:0]        insty;
  logic [7:0]        wbyte;
  logic              is_ic;
  logic              ic_pend, lsb_pend, grant_ic, grant_any;
  logic              last_byte, io_block;
  logic              do_grant, rd_step, wr_issue, wr_fin;
`ifndef MEM_ARB_LSB_PRIO_EN
  logic              last_ic;
`endif

  // A requester whose done is currently pulsing may still hold req; mask it so it is not re-granted.
  always_comb begin
    ic_pend  = ic_req && !ic_done;
    lsb_pend = lsb_req && !lsb_done;
`ifdef MEM_ARB_LSB_PRIO_EN
    grant_ic = ic_pend && !lsb_pend;
`else
    grant_ic = ic_pend && (!lsb_pend || !last_ic);
`endif
    grant_any = (ic_pend || lsb_pend) && !jp_wrong;
    case (lsb_insty[1:0])
      2'b00:   lsb_n = 3'd1;
      2'b01:   lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
    cur_addr  = base + ADDR_W'(cnt);
    last_byte = (cnt == n_bytes);
    io_block  = (cur_addr[17:16] == 2'b11) && io_buffer_full;
  end

  always_comb begin
    rd_word = rbuf;
    case (cnt)
      3'd1:    rd_word[7:0]   = mem_din;
      3'd2:    rd_word[15:8]  = mem_din;
      3'd3:    rd_word[23:16] = mem_din;
      3'd4:    rd_word[31:24] = mem_din;
      default: ;
    endcase
    ext_word = rd_word;
    case (insty[1:0])
      2'b00:   ext_word = insty[2] ? {24'h0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
      2'b01:   ext_word = insty[2] ? {16'h0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
      default: ;
    endcase
    case (cnt[1:0])
      2'd0:    wbyte = wdata[7:0];
      2'd1:    wbyte = wdata[15:8];
      2'd2:    wbyte = wdata[23:16];
      default: wbyte = wdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rdy) begin
      case (state)
        IDLE: if (grant_any) state_nxt = (grant_ic || !lsb_we) ? RD : WR;
        RD:   if (jp_wrong || last_byte) state_nxt = IDLE;
        WR:   if (last_byte) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    do_grant = rdy && (state == IDLE) && grant_any;
    rd_step  = rdy && (state == RD) && !jp_wrong;
    wr_issue = rdy && (state == WR) && !last_byte && !io_block;
    wr_fin   = rdy && (state == WR) && last_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      n_bytes  <= '0;
      base     <= '0;
      wdata    <= '0;
      rbuf     <= '0;
      insty    <= '0;
      is_ic    <= 1'b0;
      ic_done  <= 1'b0;
      ic_data  <= '0;
      lsb_done <= 1'b0;
      lsb_data <= '0;
      mem_dout <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
`ifndef MEM_ARB_LSB_PRIO_EN
      last_ic  <= 1'b0;
`endif
    end else begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      mem_wr   <= 1'b0;
      if (do_grant) begin
        base    <= grant_ic ? ic_addr : lsb_addr;
        n_bytes <= grant_ic ? FETCH_N : lsb_n;
        is_ic   <= grant_ic;
        insty   <= lsb_insty;
        wdata   <= lsb_wdata;
        rbuf    <= '0;
        cnt     <= '0;
`ifndef MEM_ARB_LSB_PRIO_EN
        last_ic <= grant_ic;
`endif
      end
      // Read byte k is captured one cycle after its address is issued, so the last byte lands with done.
      if (rd_step) begin
        cnt <= cnt + 3'd1;
        if (!last_byte) mem_a <= cur_addr;
        if (cnt != 3'd0) rbuf <= rd_word;
        if (last_byte) begin
          if (is_ic) begin
            ic_done <= 1'b1;
            ic_data <= rd_word;
          end else begin
            lsb_done <= 1'b1;
            lsb_data <= ext_word;
          end
        end
      end
      if (wr_issue) begin
        mem_a    <= cur_addr;
        mem_dout <= wbyte;
        mem_wr   <= 1'b1;
        cnt      <= cnt + 3'd1;
      end
      if (wr_fin) lsb_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a combinational-read byte RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, jp_wrong;
  logic        ic_req, ic_done, lsb_req, lsb_we, lsb_done, io_buffer_full, mem_wr;
  logic [31:0] ic_addr, ic_data, lsb_addr, lsb_wdata, lsb_data, mem_a;
  logic [2:0]  lsb_insty;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [0:262143];
  logic [31:0] wr_a [0:3];
  logic [7:0]  wr_d [0:3];
  int          n_checks = 0;
  int          n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .FETCH_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_insty(lsb_insty), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_data(lsb_data),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[17:0]];
  always @(posedge clk) if (mem_wr) ram[mem_a[17:0]] <= mem_dout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge and counts negedges until its done pulse.
  task automatic xact(input logic ic, input logic we, input logic [2:0] insty,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] data, output int nwr, output int first_wr);
    logic seen;
    seen = 1'b0; lat = 0; nwr = 0; first_wr = 0; data = '0;
    if (ic) begin
      ic_addr = addr; ic_req = 1'b1;
    end else begin
      lsb_we = we; lsb_insty = insty; lsb_addr = addr; lsb_wdata = wd; lsb_req = 1'b1;
    end
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (mem_wr) begin
        if (nwr < 4) begin
          wr_a[nwr] = mem_a;
          wr_d[nwr] = mem_dout;
        end
        if (nwr == 0) first_wr = lat;
        nwr++;
      end
      if (ic ? ic_done : lsb_done) begin
        seen = 1'b1;
        data = ic ? ic_data : lsb_data;
      end
    end
    ic_req = 1'b0;
    lsb_req = 1'b0;
    check_eq("xact_done_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
    check_eq("done_one_cycle", {30'b0, ic_done, lsb_done}, 32'd0);
  endtask

  int          lat, nwr, fw, n, overlaps, bad;
  int          ord [0:2];
  logic [31:0] data;

  initial begin
    rst = 1'b0; rdy = 1'b1; jp_wrong = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_we = 1'b0;
    lsb_insty = '0; lsb_addr = '0; lsb_wdata = '0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
    ram[18'h040] = 8'h80;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_ctl", {21'b0, mem_wr, ic_done, lsb_done, mem_dout}, 32'd0);
    check_eq("rst_data", ic_data | lsb_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Both requesters held high: expect alternating service starting from IC (LSB with priority build).
    ic_addr = 32'h100; lsb_we = 1'b0; lsb_insty = 3'b000; lsb_addr = 32'h40;
    ic_req = 1'b1; lsb_req = 1'b1; n = 0; overlaps = 0;
    for (int i = 0; i < 80 && n < 3; i++) begin
      @(negedge clk);
      if (ic_done && lsb_done) overlaps++;
      if (ic_done) begin ord[n] = 1; n++; end
      else if (lsb_done) begin ord[n] = 2; n++; end
    end
    ic_req = 1'b0; lsb_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rr_count", n, 3);
    check_eq("rr_overlap", overlaps, 0);
`ifdef MEM_ARB_LSB_PRIO_EN
    check_eq("prio_first", ord[0], 2);
    check_eq("prio_second", ord[1], 1);
    check_eq("prio_third", ord[2], 2);
`else
    check_eq("rr_first", ord[0], 1);
    check_eq("rr_second", ord[1], 2);
    check_eq("rr_third", ord[2], 1);
`endif

    xact(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, lat, data, nwr, fw);
    check_eq("fetch_lat", lat, 6);
    check_eq("fetch_data", data, 32'h0000_0513);
    check_eq("fetch_no_wr", nwr, 0);

    xact(1'b0, 1'b0, 3'b000, 32'h40, 32'h0, lat, data, nwr, fw);
    check_eq("lb_lat", lat, 3);
    check_eq("lb_sext", data, 32'hFFFF_FF80);
    xact(1'b0, 1'b0, 3'b100, 32'h40, 32'h0, lat, data, nwr, fw);
    check_eq("lbu_zext", data, 32'h0000_0080);

    xact(1'b0, 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, lat, data, nwr, fw);
    check_eq("sw_nwr", nwr, 4);
    check_eq("sw_first", fw, 2);
    check_eq("sw_lat", lat, 6);
    bad = 0;
    for (int i = 0; i < 4; i++) if (wr_a[i] != 32'h200 + 32'(i)) bad++;
    check_eq("sw_addrs", bad, 0);
    check_eq("sw_bytes", {wr_d[3], wr_d[2], wr_d[1], wr_d[0]}, 32'hDEAD_BEEF);
    xact(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, lat, data, nwr, fw);
    check_eq("lw_back", data, 32'hDEAD_BEEF);
    xact(1'b0, 1'b0, 3'b001, 32'h202, 32'h0, lat, data, nwr, fw);
    check_eq("lh_sext", data, 32'hFFFF_DEAD);

    io_buffer_full = 1'b1;
    fork
      xact(1'b0, 1'b1, 3'b000, 32'h30000, 32'h0000_0041, lat, data, nwr, fw);
      begin repeat (4) @(negedge clk); io_buffer_full = 1'b0; end
    join
    check_eq("io_nwr", nwr, 1);
    check_eq("io_first", fw, 5);
    check_eq("io_lat", lat, 6);
    check_eq("io_byte", {24'b0, wr_d[0]}, 32'h41);
    check_eq("io_ram", {24'b0, ram[18'h30000]}, 32'h41);

    fork
      xact(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, lat, data, nwr, fw);
      begin repeat (2) @(negedge clk); rdy = 1'b0; repeat (3) @(negedge clk); rdy = 1'b1; end
    join
    check_eq("rdy_lat", lat, 9);
    check_eq("rdy_data", data, 32'h0000_0513);
    check_eq("rdy_no_wr", nwr, 0);

    // Flush two cycles into a fetch: no completion may follow.
    ic_addr = 32'h100; ic_req = 1'b1;
    repeat (2) @(negedge clk);
    jp_wrong = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    jp_wrong = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ic_done || lsb_done || mem_wr) bad++;
    end
    check_eq("jp_abort_quiet", bad, 0);
    xact(1'b0, 1'b0, 3'b000, 32'h40, 32'h0, lat, data, nwr, fw);
    check_eq("jp_after_lat", lat, 3);

    fork
      xact(1'b0, 1'b0, 3'b000, 32'h40, 32'h0, lat, data, nwr, fw);
      begin jp_wrong = 1'b1; @(negedge clk); jp_wrong = 1'b0; end
    join
    check_eq("jp_idle_lat", lat, 4);
    check_eq("jp_idle_data", data, 32'hFFFF_FF80);

    fork
      xact(1'b0, 1'b1, 3'b000, 32'h50, 32'h0000_005A, lat, data, nwr, fw);
      begin @(negedge clk); jp_wrong = 1'b1; @(negedge clk); jp_wrong = 1'b0; end
    join
    check_eq("jp_wr_lat", lat, 3);
    check_eq("jp_wr_ram", {24'b0, ram[18'h50]}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
